// File: rtl/sev_seg_pkg.sv
// Shared definitions for the seven-segment encoder/decoder pair.
package sev_seg_pkg;

  // Active-low segment codes for hex digits 0..F, bit6 = g ... bit0 = a.
  localparam logic [6:0] SEG_CODE [0:15] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // All segments dark.
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Sampler state: TRACK waits for a settle, SETTLED waits for the input to move.
  typedef enum logic {
    TRACK   = 1'b0,
    SETTLED = 1'b1
  } dec_state_e;

endpackage

// File: rtl/sev_seg_decoder_lookup.sv
// Reverse lookup of a 7-bit active-low segment pattern to a hex digit.
module sev_seg_lookup
  import sev_seg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] digit,
  output logic       match,
  output logic       blank
);

  // Scan the code table; codes are unique so at most one entry hits.
  always_comb begin
    digit = 4'd0;
    match = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (pattern == SEG_CODE[i]) begin
        digit = 4'(i);
        match = 1'b1;
      end
    end
  end

  assign blank = (pattern == SEG_BLANK);

endmodule

// File: rtl/sev_seg_decoder.sv
// Seven-segment bus scraper: qualifies a stable active-low pattern, decodes it
// to a hex digit plus DP and offers each changed digit on a valid/ready port.
//
// Handshake: a digit transfers on a rising edge where valid_out && ready_in.
// While valid_out is high, hex_out/dp_out are held. ready_in is a don't-care
// while valid_out is low. A digit that arrives while the port is stalled is
// dropped and flagged with overrun.
module sev_seg_decoder
  import sev_seg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       segment_in,
  input  logic             ready_in,
  output logic [3:0]       hex_out,
  output logic             dp_out,
  output logic             valid_out,
  output logic             invalid_pat,
  output logic             overrun,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);

  logic [7:0] seg_q;
  logic [7:0] last_pat;
  logic [7:0] cnt;
  dec_state_e state;
  dec_state_e state_next;

  logic       same;
  logic       settle;
  logic       fresh;
  logic       deliver;
  logic       bad_pat;
  logic       drop;
  logic [3:0] lut_digit;
  logic       lut_match;
  logic       lut_blank;

  sev_seg_lookup u_lookup (
    .pattern (seg_q[6:0]),
    .digit   (lut_digit),
    .match   (lut_match),
    .blank   (lut_blank)
  );

  assign same    = (segment_in == seg_q);
  assign settle  = (state == TRACK) && (cnt == CNT_MAX) && same;
  // A settle on the pattern already reported (glitch recovery) stays silent.
  assign fresh   = settle && (seg_q != last_pat);
  assign deliver = fresh && lut_match;
  assign bad_pat = fresh && !lut_match && !lut_blank;
  assign drop    = deliver && valid_out && !ready_in;

  // Sample the bus and count consecutive identical samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q    <= 8'hFF;
      last_pat <= 8'hFF;
      cnt      <= 8'd0;
    end else begin
      seg_q <= segment_in;
      if (!same)
        cnt <= 8'd0;
      else if (cnt != CNT_MAX)
        cnt <= cnt + 8'd1;
      if (settle)
        last_pat <= seg_q;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= TRACK;
    else     state <= state_next;
  end

  // Next state: any input change rearms tracking; a settle parks in SETTLED.
  always_comb begin
    state_next = state;
    if (!same)
      state_next = TRACK;
    else if (settle)
      state_next = SETTLED;
  end

  // Output port, error pulses and saturating error counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hex_out     <= 4'd0;
      dp_out      <= 1'b0;
      valid_out   <= 1'b0;
      invalid_pat <= 1'b0;
      overrun     <= 1'b0;
      err_count   <= '0;
    end else begin
      invalid_pat <= bad_pat;
      overrun     <= drop;
      if (deliver && !drop) begin
        hex_out   <= lut_digit;
        dp_out    <= ~seg_q[7];
        valid_out <= 1'b1;
      end else if (valid_out && ready_in) begin
        valid_out <= 1'b0;
      end
      if ((bad_pat || drop) && (err_count != '1))
        err_count <= err_count + ERR_W'(1);
    end
  end

endmodule
